// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-read-port register bank with post-reset init sequencer
// Optional same-cycle write-through bypass on read ports: REG_BANK_FWD_EN.
module reg_bank_mp #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                N_READ    = 2,
    parameter int                INIT_MODE = 1,
    parameter logic [DATA_W-1:0] INIT_BASE = '0,
    parameter logic [DATA_W-1:0] INIT_STEP = DATA_W'(5)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       ready,
    output logic                       wr_drop,
    output logic [15:0]                wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ready_q, ready_d;
    logic                wr_drop_q, wr_drop_d;
    logic [15:0]         wr_count_q, wr_count_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   init_val;

    // Register 0 is loaded with zero regardless of the init pattern.
    always_comb begin
        init_val = '0;
        if (INIT_MODE == 1 && ptr_q != '0) begin
            init_val = INIT_BASE + DATA_W'(ptr_q) * INIT_STEP;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ready_d    = ready_q;
        wr_drop_d  = 1'b0;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = init_val;
                ptr_d     = ptr_q + 1'b1;
                wr_drop_d = wr_en;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_en) begin
                    if (wr_addr != '0) begin
                        mem_we     = 1'b1;
                        wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        wr_drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            ready_q    <= 1'b0;
            wr_drop_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ready_q    <= ready_d;
            wr_drop_q  <= wr_drop_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Array contents are not reset; the sequencer reloads them after every reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              fwd_hit;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REG_BANK_FWD_EN
        assign fwd_hit = wr_en && (wr_addr != '0) && (wr_addr == ra);
`else
        assign fwd_hit = 1'b0;
`endif
        assign rd_data[k*DATA_W +: DATA_W] = (!ready_q || ra == '0) ? '0 :
                                             fwd_hit ? wr_data : mem_q[ra];
    end

    assign ready    = ready_q;
    assign wr_drop  = wr_drop_q;
    assign wr_count = wr_count_q;

endmodule
